databus_gate_sequencer: RTL and testbench

Moore-style controller that sequences the 16-bit SLC-3 data bus through fetch, decode and memory-access cycles. It drives the four bus gate enables one-hot and the register load strobes and memory controls that go with each bus transfer. It sits between the memory interface and the bus multiplexer and replaces ad-hoc gate driving during fetch and load/store.

---
 rtl/databus_gate_sequencer.sv | 168 ++++++++++++++++
 tb/tb_databus_gate_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/databus_gate_sequencer.sv
// Moore sequencer for the SLC-3 data bus: walks fetch, decode and load/store
// memory cycles, driving one-hot bus gates plus the matching load strobes.
module databus_gate_sequencer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [1:0]  Mem_Op,
  output logic        GatePC,
  output logic        GateMARMUX,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_REG,
  output logic        MIO_EN,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Busy,
  output logic [15:0] Fetch_Count
);

  localparam logic [3:0] HALTED = 4'd0;
  localparam logic [3:0] F_MAR  = 4'd1;
  localparam logic [3:0] F_WAIT = 4'd2;
  localparam logic [3:0] F_MDR  = 4'd3;
  localparam logic [3:0] F_IR   = 4'd4;
  localparam logic [3:0] DECODE = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] L_MAR  = 4'd7;
  localparam logic [3:0] L_WAIT = 4'd8;
  localparam logic [3:0] L_MDR  = 4'd9;
  localparam logic [3:0] L_REG  = 4'd10;
  localparam logic [3:0] S_MAR  = 4'd11;
  localparam logic [3:0] S_MDR  = 4'd12;
  localparam logic [3:0] S_WAIT = 4'd13;

  localparam logic [2:0] WaitInit = 3'(MEM_WAIT - 1);

  logic [3:0]  state;
  logic [3:0]  stateNext;
  logic [2:0]  waitCnt;
  logic [2:0]  waitNext;
  logic [3:0]  endTarget;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= HALTED;
      waitCnt     <= 3'd0;
      Fetch_Count <= 16'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitNext;
      if (state == F_IR) begin
        Fetch_Count <= Fetch_Count + 16'd1;
      end
    end
  end

  // Where every instruction goes once it finishes: keep fetching only while Run holds.
  assign endTarget = Run ? F_MAR : HALTED;

  always_comb begin
    stateNext = state;
    waitNext  = waitCnt;
    case (state)
      HALTED: if (Run) stateNext = F_MAR;
      F_MAR: begin
        stateNext = F_WAIT;
        waitNext  = WaitInit;
      end
      F_WAIT: begin
        if (waitCnt == 3'd0) stateNext = F_MDR;
        else                 waitNext  = waitCnt - 3'd1;
      end
      F_MDR:  stateNext = F_IR;
      F_IR:   stateNext = DECODE;
      DECODE: begin
        case (Mem_Op)
          2'b01:   stateNext = L_MAR;
          2'b10:   stateNext = S_MAR;
          default: stateNext = EXEC;
        endcase
      end
      EXEC:   stateNext = endTarget;
      L_MAR: begin
        stateNext = L_WAIT;
        waitNext  = WaitInit;
      end
      L_WAIT: begin
        if (waitCnt == 3'd0) stateNext = L_MDR;
        else                 waitNext  = waitCnt - 3'd1;
      end
      L_MDR:  stateNext = L_REG;
      L_REG:  stateNext = endTarget;
      S_MAR:  stateNext = S_MDR;
      S_MDR: begin
        stateNext = S_WAIT;
        waitNext  = WaitInit;
      end
      S_WAIT: begin
        if (waitCnt == 3'd0) stateNext = endTarget;
        else                 waitNext  = waitCnt - 3'd1;
      end
      default: stateNext = HALTED;
    endcase
  end

  // Outputs depend on state alone, so an async reset clears them without a clock edge.
  always_comb begin
    GatePC     = 1'b0;
    GateMARMUX = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_PC      = 1'b0;
    LD_REG     = 1'b0;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    case (state)
      F_MAR: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      F_WAIT, L_WAIT: begin
        MIO_EN = 1'b1;
        Mem_OE = 1'b1;
      end
      F_MDR, L_MDR: begin
        MIO_EN = 1'b1;
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      F_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      EXEC: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
      end
      L_MAR, S_MAR: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      L_REG: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
      end
      S_MDR: begin
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_WAIT: Mem_WE = 1'b1;
      default: ;
    endcase
  end

  assign Busy = (state != HALTED);

endmodule

// File: tb/tb_databus_gate_sequencer.sv
// Bench for databus_gate_sequencer: two instances (MEM_WAIT 2 and 3) checked every
// cycle against a model that derives outputs from the offset into the instruction.
module tb_databus_gate_sequencer;

  localparam logic [11:0] B_GPC  = 12'h800;
  localparam logic [11:0] B_GMM  = 12'h400;
  localparam logic [11:0] B_GMDR = 12'h200;
  localparam logic [11:0] B_GALU = 12'h100;
  localparam logic [11:0] B_LMAR = 12'h080;
  localparam logic [11:0] B_LMDR = 12'h040;
  localparam logic [11:0] B_LIR  = 12'h020;
  localparam logic [11:0] B_LPC  = 12'h010;
  localparam logic [11:0] B_LREG = 12'h008;
  localparam logic [11:0] B_MIO  = 12'h004;
  localparam logic [11:0] B_OE   = 12'h002;
  localparam logic [11:0] B_WE   = 12'h001;

  logic       Clk = 1'b0;
  logic       clkRun = 1'b1;
  logic       Reset;
  logic       Run;
  logic [1:0] Mem_Op;

  wire [11:0] outA;
  wire [11:0] outB;
  wire        busyA;
  wire        busyB;
  wire [15:0] cntA;
  wire [15:0] cntB;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state per instance: active flag, cycle offset within instruction, op, fetch count.
  int          wv[2]    = '{2, 3};
  bit          mBusy[2] = '{1'b0, 1'b0};
  int          mT[2]    = '{0, 0};
  logic [1:0]  mOp[2]   = '{2'b00, 2'b00};
  logic [15:0] mCnt[2]  = '{16'd0, 16'd0};

  databus_gate_sequencer #(.MEM_WAIT(2)) dutA (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Mem_Op(Mem_Op),
    .GatePC(outA[11]), .GateMARMUX(outA[10]), .GateMDR(outA[9]), .GateALU(outA[8]),
    .LD_MAR(outA[7]), .LD_MDR(outA[6]), .LD_IR(outA[5]), .LD_PC(outA[4]),
    .LD_REG(outA[3]), .MIO_EN(outA[2]), .Mem_OE(outA[1]), .Mem_WE(outA[0]),
    .Busy(busyA), .Fetch_Count(cntA)
  );

  databus_gate_sequencer #(.MEM_WAIT(3)) dutB (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Mem_Op(Mem_Op),
    .GatePC(outB[11]), .GateMARMUX(outB[10]), .GateMDR(outB[9]), .GateALU(outB[8]),
    .LD_MAR(outB[7]), .LD_MDR(outB[6]), .LD_IR(outB[5]), .LD_PC(outB[4]),
    .LD_REG(outB[3]), .MIO_EN(outB[2]), .Mem_OE(outB[1]), .Mem_WE(outB[0]),
    .Busy(busyB), .Fetch_Count(cntB)
  );

  always begin
    #5;
    if (clkRun) Clk = ~Clk;
  end

  function automatic int instrLen(int w, logic [1:0] op);
    if (op == 2'b01) return 2 * w + 7;
    if (op == 2'b10) return 2 * w + 6;
    return w + 5;
  endfunction

  function automatic logic [11:0] expOut(int w, int t, logic [1:0] op);
    int u;
    u = t - (w + 4);
    if (t == 0)     return B_GPC | B_LMAR | B_LPC;
    if (t <= w)     return B_MIO | B_OE;
    if (t == w + 1) return B_MIO | B_OE | B_LMDR;
    if (t == w + 2) return B_GMDR | B_LIR;
    if (t == w + 3) return 12'd0;
    if (op == 2'b01) begin
      if (u == 0)     return B_GMM | B_LMAR;
      if (u <= w)     return B_MIO | B_OE;
      if (u == w + 1) return B_MIO | B_OE | B_LMDR;
      return B_GMDR | B_LREG;
    end
    if (op == 2'b10) begin
      if (u == 0) return B_GMM | B_LMAR;
      if (u == 1) return B_GALU | B_LMDR;
      return B_WE;
    end
    return B_GALU | B_LREG;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic [1:0] op, input int cycles);
    Run = run;
    Mem_Op = op;
    repeat (cycles) @(negedge Clk);
  endtask

  // Advance the model at each clock edge (or clear it on reset), then compare both instances.
  always begin
    @(posedge Clk or posedge Reset);
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        mBusy[i] = 1'b0;
        mT[i] = 0;
        mCnt[i] = 16'd0;
      end else if (!mBusy[i]) begin
        if (Run) begin
          mBusy[i] = 1'b1;
          mT[i] = 0;
        end
      end else begin
        if (mT[i] == wv[i] + 2) mCnt[i] = mCnt[i] + 16'd1;
        if (mT[i] == wv[i] + 3) mOp[i] = Mem_Op;
        mT[i] = mT[i] + 1;
        if (mT[i] == instrLen(wv[i], mOp[i])) begin
          if (Run) mT[i] = 0;
          else     mBusy[i] = 1'b0;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [11:0] act;
      logic [11:0] exp;
      act = (i == 0) ? outA : outB;
      exp = mBusy[i] ? expOut(wv[i], mT[i], mOp[i]) : 12'd0;
      checkOutput(i == 0 ? "outputsA" : "outputsB", {20'd0, act}, {20'd0, exp});
      checkOutput(i == 0 ? "busyA" : "busyB", {31'd0, (i == 0) ? busyA : busyB}, {31'd0, mBusy[i]});
      checkOutput(i == 0 ? "countA" : "countB", {16'd0, (i == 0) ? cntA : cntB}, {16'd0, mCnt[i]});
      checkOutput(i == 0 ? "gateOneHotA" : "gateOneHotB", {31'd0, ($countones(act[11:8]) <= 1)}, 32'd1);
      checkOutput(i == 0 ? "oeWeExclA" : "oeWeExclB", {31'd0, (act[1] & act[0])}, 32'd0);
    end
  end

  initial begin
    int weCnt;
    int oeCnt;
    Reset = 1'b1;
    Run = 1'b0;
    Mem_Op = 2'b00;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("resetOutputs", {20'd0, outA}, 32'd0);
    checkOutput("resetBusy", {31'd0, busyA}, 32'd0);
    checkOutput("resetCount", {16'd0, cntA}, 32'd0);

    // Single none-op instruction at MEM_WAIT=2.
    applyStimulus(1'b1, 2'b00, 1);
    checkOutput("noneCycle1", {20'd0, outA}, {20'd0, B_GPC | B_LMAR | B_LPC});
    applyStimulus(1'b0, 2'b00, 3);
    checkOutput("noneCycle4", {20'd0, outA}, {20'd0, B_MIO | B_OE | B_LMDR});
    applyStimulus(1'b0, 2'b00, 1);
    checkOutput("noneCycle5", {20'd0, outA}, {20'd0, B_GMDR | B_LIR});
    applyStimulus(1'b0, 2'b00, 2);
    checkOutput("noneCycle7", {20'd0, outA}, {20'd0, B_GALU | B_LREG});
    applyStimulus(1'b0, 2'b00, 1);
    checkOutput("noneHaltBusy", {31'd0, busyA}, 32'd0);
    checkOutput("noneHaltCount", {16'd0, cntA}, 32'd1);
    applyStimulus(1'b0, 2'b00, 2);

    // Load at MEM_WAIT=2: 11 cycles.
    applyStimulus(1'b1, 2'b01, 1);
    applyStimulus(1'b0, 2'b01, 6);
    checkOutput("loadMar", {20'd0, outA}, {20'd0, B_GMM | B_LMAR});
    applyStimulus(1'b0, 2'b01, 3);
    checkOutput("loadMdr", {20'd0, outA}, {20'd0, B_MIO | B_OE | B_LMDR});
    applyStimulus(1'b0, 2'b01, 1);
    checkOutput("loadReg", {20'd0, outA}, {20'd0, B_GMDR | B_LREG});
    applyStimulus(1'b0, 2'b01, 1);
    checkOutput("loadDoneBusy", {31'd0, busyA}, 32'd0);
    applyStimulus(1'b0, 2'b00, 3);

    // Store at MEM_WAIT=3 on the second instance.
    weCnt = 0;
    oeCnt = 0;
    applyStimulus(1'b1, 2'b10, 1);
    for (int c = 1; c <= 14; c++) begin
      if (outB[0]) weCnt++;
      if (c >= 8 && c <= 12 && outB[1]) oeCnt++;
      if (c == 8) checkOutput("storeMar", {20'd0, outB}, {20'd0, B_GMM | B_LMAR});
      if (c == 9) checkOutput("storeMdr", {20'd0, outB}, {20'd0, B_GALU | B_LMDR});
      applyStimulus(1'b0, 2'b10, 1);
    end
    checkOutput("storeWeCycles", weCnt, 32'd3);
    checkOutput("storeOeCycles", oeCnt, 32'd0);

    // Reset with the clock stopped mid-instruction.
    applyStimulus(1'b1, 2'b00, 3);
    clkRun = 1'b0;
    Run = 1'b0;
    #3 Reset = 1'b1;
    #1;
    checkOutput("stoppedResetOutA", {20'd0, outA}, 32'd0);
    checkOutput("stoppedResetOutB", {20'd0, outB}, 32'd0);
    checkOutput("stoppedResetBusy", {31'd0, busyA}, 32'd0);
    checkOutput("stoppedResetCount", {16'd0, cntA}, 32'd0);
    clkRun = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Continuous run, Run dropped during the third instruction's F_WAIT.
    applyStimulus(1'b1, 2'b00, 16);
    applyStimulus(1'b0, 2'b00, 5);
    checkOutput("runDropExec", {20'd0, outA}, {20'd0, B_GALU | B_LREG});
    applyStimulus(1'b0, 2'b00, 1);
    checkOutput("runDropBusy", {31'd0, busyA}, 32'd0);
    checkOutput("runDropCount", {16'd0, cntA}, 32'd3);
    applyStimulus(1'b0, 2'b00, 3);

    // Reset pulse during L_WAIT, then restart from F_MAR with the count cleared.
    applyStimulus(1'b1, 2'b01, 8);
    checkOutput("loadWaitBefore", {20'd0, outA}, {20'd0, B_MIO | B_OE});
    #2 Reset = 1'b1;
    #1;
    checkOutput("pulseResetOut", {20'd0, outA}, 32'd0);
    checkOutput("pulseResetCount", {16'd0, cntA}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("restartFetch", {20'd0, outA}, {20'd0, B_GPC | B_LMAR | B_LPC});
    checkOutput("restartCount", {16'd0, cntA}, 32'd0);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 500; n++) begin
      Run = ($urandom_range(0, 7) != 0);
      Mem_Op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      @(negedge Clk);
    end
    Run = 1'b0;
    repeat (20) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
